// File: rtl/axi_slave_bresp_sender_pkg.sv
// AXI write-response encodings and the {bid, bresp} FIFO word layout shared by the
// B-channel sender and its testbench.
package axi_slave_bresp_sender_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bresp_e;

    // FIFO word = {bid, bresp}: bresp sits in the low two bits.
    localparam int BRESP_LSB = 0;
    localparam int BRESP_W   = 2;
    localparam int BID_LSB   = BRESP_LSB + BRESP_W;

    // SLVERR and DECERR both have the MSB set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_slave_bresp_sender_if.sv
// Write-back FIFO read port plus AXI B channel. The sender uses the master view;
// the FIFO and interconnect side use the slave view.
interface axi_slave_bresp_sender_if #(
    parameter int ID_WIDTH = 9
);
    localparam int FIFO_WIDTH = ID_WIDTH + 2;

    logic [FIFO_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_empty;
    logic                  fifo_rd_en;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        input  fifo_rd_data,
        input  fifo_rd_empty,
        input  bready,
        output fifo_rd_en,
        output bid,
        output bresp,
        output bvalid
    );

    modport slave (
        output fifo_rd_data,
        output fifo_rd_empty,
        output bready,
        input  fifo_rd_en,
        input  bid,
        input  bresp,
        input  bvalid
    );

endinterface

// File: rtl/axi_slave_bresp_sender_skid.sv
// Two-entry output/skid register pair: in_dat lands in O (or S if O is held); 0-cycle
// pass to O when free. Holds out_vld/out_dat steady while out_rdy is low; S refills O on handshake.
module axi_slave_bresp_sender_skid #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_rdy,
    output logic [1:0]       fill
);

    logic             o_vld;
    logic [WIDTH-1:0] o_dat;
    logic             s_vld;
    logic [WIDTH-1:0] s_dat;
    logic             hs;

    assign hs      = o_vld & out_rdy;
    assign out_vld = o_vld;
    assign out_dat = o_dat;
    assign fill    = {1'b0, o_vld} + {1'b0, s_vld};

    // S is only ever valid while O is valid, so the middle branch always sees S empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_vld <= 1'b0;
            o_dat <= '0;
            s_vld <= 1'b0;
            s_dat <= '0;
        end else if (hs && s_vld) begin
            o_dat <= s_dat;
            s_vld <= in_vld;
            if (in_vld) begin
                s_dat <= in_dat;
            end
        end else if (!o_vld || hs) begin
            o_vld <= in_vld;
            if (in_vld) begin
                o_dat <= in_dat;
            end
        end else if (in_vld) begin
            s_vld <= 1'b1;
            s_dat <= in_dat;
        end
    end

endmodule

// File: rtl/axi_slave_bresp_sender.sv
// Pops {bid, bresp} words from the write-back FIFO onto the AXI B channel; bvalid 2 cycles
// after the FIFO goes non-empty, one response per cycle. bready low: stops popping once O and S hold 2 words.
module axi_slave_bresp_sender
    import axi_slave_bresp_sender_pkg::*;
#(
    parameter int ID_WIDTH   = 9,
    parameter int FIFO_WIDTH = ID_WIDTH + 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    axi_slave_bresp_sender_if.master bus,
    output logic [CNT_WIDTH-1:0]  resp_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    logic                  inflight;
    logic [1:0]            fill;
    logic                  out_vld;
    logic [FIFO_WIDTH-1:0] out_dat;
    logic                  hs;
    logic [2:0]            occ;
    logic                  pop;

    assign hs  = out_vld & bus.bready;
    assign occ = {1'b0, fill} + {2'b00, inflight};

    // Room is judged after this cycle's handshake so streaming never leaves a bubble.
    // rstn gating keeps the pop request low throughout reset.
    assign pop = rstn & ~bus.fifo_rd_empty & ((occ - {2'b00, hs}) < 3'd2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= 1'b0;
        end else begin
            inflight <= pop;
        end
    end

    axi_slave_bresp_sender_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .in_vld  (inflight),
        .in_dat  (bus.fifo_rd_data),
        .out_vld (out_vld),
        .out_dat (out_dat),
        .out_rdy (bus.bready),
        .fill    (fill)
    );

    assign bus.fifo_rd_en = pop;
    assign bus.bvalid     = out_vld;
    assign bus.bid        = out_dat[BID_LSB +: ID_WIDTH];
    assign bus.bresp      = out_dat[BRESP_LSB +: BRESP_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_cnt <= '0;
            err_cnt  <= '0;
        end else if (hs) begin
            resp_cnt <= resp_cnt + CNT_WIDTH'(1);
            if (resp_is_err(out_dat[BRESP_LSB +: BRESP_W])) begin
                err_cnt <= err_cnt + CNT_WIDTH'(1);
            end
        end
    end

    a_occ_bound: assert property (@(posedge clk) disable iff (!rstn) occ <= 3'd2);
    a_b_stable:  assert property (@(posedge clk) disable iff (!rstn)
                                  (out_vld && !bus.bready) |=> (out_vld && $stable(out_dat)));

endmodule

// File: tb/tb_axi_slave_bresp_sender.sv
// Directed bench for the B-channel sender: behavioural FIFO, negedge monitor, table plus sequences.
module tb_axi_slave_bresp_sender;
    import axi_slave_bresp_sender_pkg::*;

    localparam int IDW   = 9;
    localparam int FW    = IDW + 2;
    localparam int CW    = 16;
    localparam int DEPTH = 4096;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_slave_bresp_sender_if #(.ID_WIDTH(IDW)) bus();
    logic [CW-1:0] resp_cnt;
    logic [CW-1:0] err_cnt;

    axi_slave_bresp_sender #(
        .ID_WIDTH   (IDW),
        .FIFO_WIDTH (FW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .resp_cnt (resp_cnt),
        .err_cnt  (err_cnt)
    );

    // Behavioural FIFO with one-cycle read latency, flushed by the shared reset.
    logic [FW-1:0] fifo_mem [DEPTH];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    int pop_empty_errs = 0;

    assign bus.fifo_rd_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (!rstn) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en) begin
            if (wr_ptr == rd_ptr) begin
                pop_empty_errs <= pop_empty_errs + 1;
            end else begin
                bus.fifo_rd_data <= fifo_mem[rd_ptr % DEPTH];
                rd_ptr  <= rd_ptr + 1;
                pop_cnt <= pop_cnt + 1;
            end
        end
    end

    task automatic push(input logic [IDW-1:0] id, input logic [1:0] resp);
        fifo_mem[wr_ptr % DEPTH] = {id, resp};
        wr_ptr = wr_ptr + 1;
    endtask

    // B-channel monitor: logs every handshake and flags any change while stalled.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rx_cnt = 0;
    int stab_errs = 0;
    logic [IDW-1:0] rx_bid  [DEPTH];
    logic [1:0]     rx_resp [DEPTH];
    int             rx_cyc  [DEPTH];
    logic           prev_stall = 1'b0;
    logic [FW-1:0]  prev_word  = '0;

    always @(negedge clk) begin
        if (rstn && prev_stall && (!bus.bvalid || ({bus.bid, bus.bresp} != prev_word))) begin
            stab_errs <= stab_errs + 1;
        end
        prev_stall <= rstn & bus.bvalid & ~bus.bready;
        prev_word  <= {bus.bid, bus.bresp};
        if (bus.bvalid && bus.bready) begin
            rx_bid[rx_cnt % DEPTH]  <= bus.bid;
            rx_resp[rx_cnt % DEPTH] <= bus.bresp;
            rx_cyc[rx_cnt % DEPTH]  <= cyc;
            rx_cnt <= rx_cnt + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_rx(input int base, input int n, input int budget, input string name);
        int k = 0;
        while ((rx_cnt - base) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, rx_cnt - base, n);
    endtask

    // Expected stream: bid = index mod 512; SLVERR on every 7th word when err7 is set.
    task automatic check_order(input int base, input int n, input bit err7,
                               input bit no_gap, input string name);
        int errs = 0;
        for (int k = 0; k < n; k++) begin
            logic [IDW-1:0] eid;
            logic [1:0]     eresp;
            eid   = IDW'(k % 512);
            eresp = (err7 && (k % 7 == 6)) ? RESP_SLVERR : RESP_OKAY;
            if (rx_bid[(base + k) % DEPTH] != eid || rx_resp[(base + k) % DEPTH] != eresp) errs++;
            if (no_gap && k > 0 && rx_cyc[(base + k) % DEPTH] != rx_cyc[(base + k - 1) % DEPTH] + 1) errs++;
        end
        check(name, errs, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
        logic [IDW-1:0] exp_bid;
        logic [1:0]     exp_bresp;
        logic [CW-1:0]  exp_resp_cnt;
        logic [CW-1:0]  exp_err_cnt;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int base;
        int p0;

        vecs[0] = '{id: 9'h1A5, resp: RESP_OKAY,   exp_bid: 9'h1A5, exp_bresp: 2'b00, exp_resp_cnt: 16'd1, exp_err_cnt: 16'd0};
        vecs[1] = '{id: 9'h000, resp: RESP_EXOKAY, exp_bid: 9'h000, exp_bresp: 2'b01, exp_resp_cnt: 16'd2, exp_err_cnt: 16'd0};
        vecs[2] = '{id: 9'h1FF, resp: RESP_SLVERR, exp_bid: 9'h1FF, exp_bresp: 2'b10, exp_resp_cnt: 16'd3, exp_err_cnt: 16'd1};
        vecs[3] = '{id: 9'h0F0, resp: RESP_DECERR, exp_bid: 9'h0F0, exp_bresp: 2'b11, exp_resp_cnt: 16'd4, exp_err_cnt: 16'd2};

        bus.bready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_bvalid",     bus.bvalid, 0);
        check("reset_bid",        bus.bid, 0);
        check("reset_bresp",      bus.bresp, 0);
        check("reset_fifo_rd_en", bus.fifo_rd_en, 0);
        check("reset_resp_cnt",   resp_cnt, 0);
        check("reset_err_cnt",    err_cnt, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        bus.bready = 1'b1;

        // Single words: pop in the same cycle, bvalid two cycles later, one-cycle handshake.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            push(vecs[i].id, vecs[i].resp);
            @(negedge clk);
            check($sformatf("v%0d_rd_en", i), bus.fifo_rd_en, 1);
            @(negedge clk);
            check($sformatf("v%0d_bvalid_n1", i), bus.bvalid, 0);
            @(negedge clk);
            check($sformatf("v%0d_bvalid_n2", i), bus.bvalid, 1);
            check($sformatf("v%0d_bid", i), bus.bid, vecs[i].exp_bid);
            check($sformatf("v%0d_bresp", i), bus.bresp, vecs[i].exp_bresp);
            @(negedge clk);
            check($sformatf("v%0d_bvalid_done", i), bus.bvalid, 0);
            check($sformatf("v%0d_resp_cnt", i), resp_cnt, vecs[i].exp_resp_cnt);
            check($sformatf("v%0d_err_cnt", i), err_cnt, vecs[i].exp_err_cnt);
        end

        // Burst of 64 with bready held high.
        do_reset();
        bus.bready = 1'b1;
        base = rx_cnt;
        for (int i = 0; i < 64; i++) push(IDW'(i), RESP_OKAY);
        wait_rx(base, 64, 200, "burst_count");
        check_order(base, 64, 1'b0, 1'b1, "burst_order_no_gap");
        check("burst_resp_cnt", resp_cnt, 64);
        check("burst_err_cnt", err_cnt, 0);

        // Backpressure: only O and S fill, then the channel holds.
        do_reset();
        bus.bready = 1'b0;
        base = rx_cnt;
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) push(IDW'(i), RESP_OKAY);
        repeat (20) @(negedge clk);
        check("bp_pops", pop_cnt - p0, 2);
        check("bp_rd_en_low", bus.fifo_rd_en, 0);
        check("bp_bvalid", bus.bvalid, 1);
        check("bp_bid", bus.bid, 0);
        check("bp_no_hs", rx_cnt - base, 0);
        @(posedge clk); #1;
        bus.bready = 1'b1;
        wait_rx(base, 8, 50, "bp_count");
        check_order(base, 8, 1'b0, 1'b1, "bp_order_no_gap");

        // Random bready over 1024 words with SLVERR on every 7th.
        do_reset();
        base = rx_cnt;
        p0 = pop_cnt;
        for (int i = 0; i < 1024; i++) push(IDW'(i % 512), (i % 7 == 6) ? RESP_SLVERR : RESP_OKAY);
        for (int c = 0; c < 8000 && (rx_cnt - base) < 1024; c++) begin
            @(posedge clk); #1;
            bus.bready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("rand_count", rx_cnt - base, 1024);
        check_order(base, 1024, 1'b1, 1'b0, "rand_order");
        check("rand_resp_cnt", resp_cnt, 1024);
        check("rand_err_cnt", err_cnt, 146);
        check("rand_pops", pop_cnt - p0, 1024);

        // Reset while O and S both hold a response.
        bus.bready = 1'b0;
        p0 = pop_cnt;
        for (int i = 0; i < 4; i++) push(IDW'(9'h10 + i), RESP_OKAY);
        repeat (6) @(negedge clk);
        check("mid_pre_bvalid", bus.bvalid, 1);
        check("mid_pre_pops", pop_cnt - p0, 2);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        check("mid_bvalid", bus.bvalid, 0);
        check("mid_bid", bus.bid, 0);
        check("mid_bresp", bus.bresp, 0);
        check("mid_rd_en", bus.fifo_rd_en, 0);
        check("mid_resp_cnt", resp_cnt, 0);
        check("mid_err_cnt", err_cnt, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        bus.bready = 1'b1;
        base = rx_cnt;
        repeat (10) @(negedge clk);
        check("mid_no_stale", rx_cnt - base, 0);
        check("mid_bvalid_after", bus.bvalid, 0);

        // Counter wrap: 65535 DECERR handshakes, then one more.
        base = rx_cnt;
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk); #1;
            push(IDW'(i % 512), RESP_DECERR);
        end
        wait_rx(base, 65535, 20, "wrap_count");
        check("wrap_resp_ffff", resp_cnt, 16'hFFFF);
        check("wrap_err_ffff", err_cnt, 16'hFFFF);
        @(posedge clk); #1;
        push(9'h055, RESP_DECERR);
        wait_rx(base, 65536, 20, "wrap_count_last");
        check("wrap_resp_zero", resp_cnt, 0);
        check("wrap_err_zero", err_cnt, 0);

        check("b_stable_while_stalled", stab_errs, 0);
        check("no_pop_while_empty", pop_empty_errs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
